// File: rtl/encode_sample_gen.sv
// encode_sample_gen: periodic encoder W/X sample generator with a single-cycle update strobe.
// Optional macro ENCODE_JITTER_EN alternates long/short update intervals by +/-JITTER clocks.
`default_nettype none

module encode_sample_gen #(
  parameter real TCQ             = 0.1,
  parameter int  ENCODE_WID      = 32,
  parameter int  ENCODE_MASK_WID = 18,
  parameter int  PERIOD_WID      = 16,
  parameter int  JITTER          = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [PERIOD_WID-1:0] period_i,
  input  logic [ENCODE_WID-1:0] w_init_i,
  input  logic [ENCODE_WID-1:0] x_init_i,
  input  logic [ENCODE_WID-1:0] w_step_i,
  input  logic [ENCODE_WID-1:0] x_step_i,
  input  logic                  x_dir_i,
  output logic                  busy_o,
  output logic                  encode_update_o,
  output logic [ENCODE_WID-1:0] encode_w_o,
  output logic [ENCODE_WID-1:0] encode_x_o,
  output logic [31:0]           update_cnt_o
);

  localparam int CNT_WID = PERIOD_WID + 1;
  localparam logic [ENCODE_WID-1:0] W_MAX =
    {{(ENCODE_WID-ENCODE_MASK_WID){1'b0}}, {ENCODE_MASK_WID{1'b1}}};

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state;
  logic [PERIOD_WID-1:0] r_period;
  logic [CNT_WID-1:0]    r_cnt;
  logic                  r_phase;
  logic                  r_busy;
  logic                  r_update;
  logic [ENCODE_WID-1:0] r_w;
  logic [ENCODE_WID-1:0] r_x;
  logic [31:0]           r_update_cnt;

  logic [PERIOD_WID-1:0] w_period_start;
  logic [ENCODE_WID-1:0] w_w_sum;
  logic [ENCODE_WID-1:0] w_w_next;
  logic [ENCODE_WID-1:0] w_x_next;
  logic [CNT_WID-1:0]    w_term;
  logic                  w_unused;

  assign w_period_start = (period_i == '0) ? PERIOD_WID'(1) : period_i;

  // Overflowing the W ring skips zero: the wrapped value is offset by one.
  assign w_w_sum  = r_w + w_step_i;
  assign w_w_next = (w_w_sum > W_MAX)
                  ? ({{(ENCODE_WID-ENCODE_MASK_WID){1'b0}}, w_w_sum[ENCODE_MASK_WID-1:0]}
                     + ENCODE_WID'(1))
                  : w_w_sum;
  assign w_x_next = x_dir_i ? (r_x + x_step_i) : (r_x - x_step_i);

`ifdef ENCODE_JITTER_EN
  logic [CNT_WID-1:0] w_term_long;
  logic [CNT_WID-1:0] w_term_short;
  assign w_term_long  = {1'b0, r_period} + CNT_WID'(JITTER);
  assign w_term_short = (r_period > PERIOD_WID'(JITTER))
                      ? ({1'b0, r_period} - CNT_WID'(JITTER))
                      : CNT_WID'(1);
  assign w_term       = r_phase ? w_term_short : w_term_long;
`else
  assign w_term = {1'b0, r_period};
`endif

  assign w_unused = (TCQ > 0.0) ^ (JITTER != 0) ^ r_phase;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_period     <= '0;
      r_cnt        <= '0;
      r_phase      <= 1'b0;
      r_busy       <= 1'b0;
      r_update     <= 1'b0;
      r_w          <= '0;
      r_x          <= '0;
      r_update_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_update <= 1'b0;
          if (start_i) begin
            r_period     <= w_period_start;
            r_w          <= w_init_i;
            r_x          <= x_init_i;
            r_cnt        <= '0;
            r_phase      <= 1'b0;
            r_update_cnt <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          // Stop has priority over a coinciding terminal count.
          if (stop_i) begin
            r_update <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_cnt == w_term) begin
            r_cnt        <= '0;
            r_update     <= 1'b1;
            r_update_cnt <= r_update_cnt + 32'd1;
            r_w          <= w_w_next;
            r_x          <= w_x_next;
            r_phase      <= ~r_phase;
          end else begin
            r_cnt    <= r_cnt + CNT_WID'(1);
            r_update <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_update <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o          = r_busy;
  assign encode_update_o = r_update;
  assign encode_w_o      = r_w;
  assign encode_x_o      = r_x;
  assign update_cnt_o    = r_update_cnt;

endmodule

`default_nettype wire

// File: doc/encode_sample_gen.md
Name: encode_sample_gen

Overview:
- Synthesizes the coarse encoder sample stream that the encode interpolators consume: a periodic single-cycle encode_update strobe with W (unsigned, 18-bit masked ring) and X (signed, 32-bit) positions.
- Used as an on-chip stimulus source and stage-motion emulator in place of the real encoder front end.
- Drives encode_process / encode_process_v2 directly.

Parameters:
- TCQ, 0.1, register clock-to-out delay used in simulation only.
- ENCODE_WID, 32, width of the W and X outputs.
- ENCODE_MASK_WID, 18, valid W bit width; W ring maximum is 2^ENCODE_MASK_WID-1.
- PERIOD_WID, 16, width of the period counter.
- JITTER, 3, period deviation in clocks; used only with ENCODE_JITTER_EN.

Ports:
- clk_i  in  1  system clock (100 MHz).
- rst_n_i  in  1  asynchronous reset, active-low.
- start_i  in  1  pulse; latches configuration and starts generation.
- stop_i  in  1  pulse; halts generation.
- period_i  in  PERIOD_WID  terminal count; update interval is period_i+1 clocks.
- w_init_i  in  ENCODE_WID  initial W; must be at most 2^ENCODE_MASK_WID-1.
- x_init_i  in  ENCODE_WID  initial X, two's complement.
- w_step_i  in  ENCODE_WID  W increment per update; must be below 2^ENCODE_MASK_WID.
- x_step_i  in  ENCODE_WID  X magnitude step per update.
- x_dir_i  in  1  1 = X adds step, 0 = X subtracts step.
- busy_o  out  1  high while in RUN.
- encode_update_o  out  1  one-cycle strobe.
- encode_w_o  out  ENCODE_WID  W sample.
- encode_x_o  out  ENCODE_WID  X sample.
- update_cnt_o  out  32  number of strobes since start.

Behaviour:
- Reset: while rst_n_i is low, all registers clear asynchronously.
  - State = IDLE.
  - busy_o = 0, encode_update_o = 0.
  - encode_w_o = 0, encode_x_o = 0, update_cnt_o = 0.
  - Internal period counter = 0.
- FSM states: IDLE and RUN.
- IDLE:
  - On start_i: latch period_reg = max(period_i, 1); a value of 0 is treated as 1.
  - Load encode_w_o = w_init_i and encode_x_o = x_init_i. No strobe is issued.
  - Clear the counter and update_cnt_o; go to RUN. busy_o goes high the next cycle.
  - stop_i in IDLE is ignored.
- RUN:
  - The counter increments each clock.
  - When counter == period_reg: the counter returns to 0, encode_update_o = 1 for that single registered cycle, and update_cnt_o increments (wraps at 2^32).
  - In that same cycle, encode_w_o and encode_x_o present the new values.
  - First strobe occurs exactly period_reg+1 clocks after the start_i cycle. Strobes repeat every period_reg+1 clocks.
- Step inputs (w_step_i, x_step_i, x_dir_i) are sampled live at each terminal count. period_i is sampled only at start.
- W arithmetic:
  - sum = encode_w_o + w_step_i, computed at ENCODE_WID width.
  - If sum > 2^ENCODE_MASK_WID-1, next W = sum[ENCODE_MASK_WID-1:0] + 1.
  - Otherwise next W = sum.
  - W is zero-extended; bits above ENCODE_MASK_WID are always 0.
- X arithmetic: next X = X + x_step_i or X - x_step_i, mod 2^ENCODE_WID. No saturation.
- Between strobes, W and X hold their values.
- stop_i in RUN:
  - Go to IDLE; busy_o is low the next cycle.
  - Outputs W, X and update_cnt_o hold.
  - If stop_i coincides with terminal count, stop wins: no strobe and no value update.
- start_i while in RUN is ignored. start_i and stop_i together in RUN behave as stop.
- Reset asserted mid-RUN clears everything immediately. No strobe is issued after reset release until a new start_i.

Optional Feature:
- Macro ENCODE_JITTER_EN.
- When defined: intervals alternate between period_reg+1+JITTER and period_reg+1-JITTER clocks, starting with the longer one after each start, emulating encoder timing jitter.
  - period_i must exceed JITTER; otherwise the effective period is clamped to a minimum of 1.
- When undefined: fixed interval period_reg+1, and the JITTER parameter is unused.

Test Plan:
- Two strobes: period_i=6253, w_init=261754, w_step=956, x_init=100, x_step=500, x_dir=1, start.
  - First strobe at 6254 clocks after start: W=567 (262710 wraps to 566, +1), X=600.
  - Second strobe 6254 clocks later: W=1523, X=1100. update_cnt_o=2.
- Exact wrap boundary: w_init=262143, w_step=0 → W stays 262143. Then w_step=1 → W=1.
- Subtract: x_init=100, x_step=500, x_dir=0 → X=0xFFFFFE70 (-400) on the first strobe.
- Stop on terminal count: period_i=10, assert stop_i on cycle 11 after start.
  - No strobe is issued; busy_o falls the next cycle; W/X keep init values.
  - start_i in RUN has no effect.
- Reset mid-run: drop rst_n_i at counter=3000.
  - All outputs go to 0 within the same cycle, with no clock edge needed.
  - No strobe occurs after release without a new start_i.
- Jitter build (ENCODE_JITTER_EN, JITTER=3, period_i=6249): strobe intervals alternate 6253, 6247, 6253… clocks.
